// File: rtl/fetch_sequencer.sv
// fetch_sequencer: arbitrates instruction memory between the boot loader and
// instruction fetch, and delivers a valid-qualified instruction stream with stall/branch/halt/fault handling.
module fetch_sequencer #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic              run,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              halt_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              imem_re,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic [31:0]       pc_out,
    output logic [ADDR_W:0]   ld_count,
    output logic [1:0]        state,
    output logic              fault
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
    localparam logic [ADDR_W:0] LAST_WORD = {1'b0, {ADDR_W{1'b1}}};
    state_t            state_q, state_d;
    logic [31:0]       fpc_q, fpc_d, pc_q, pc_d, fetch_addr;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d, fault_q, fault_d, redirect, bad_addr;
    assign redirect   = branch_taken & valid_q;
    assign fetch_addr = redirect ? branch_target : fpc_q;
    assign bad_addr   = (|fetch_addr[1:0]) | (|fetch_addr[31:ADDR_W+2]);
    // enables are suppressed during the reset cycle so a mid-load reset never writes
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        ld_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_re    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    if (start_load) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else if (run) state_d = RUN;
                end
                LOAD: begin
                    ld_ready  = 1'b1;
                    imem_addr = cnt_q[ADDR_W-1:0];
                    if (ld_valid) begin
                        imem_we    = 1'b1;
                        imem_wdata = ld_data;
                        cnt_d      = cnt_q + 1'b1;
                        if (ld_last || cnt_q == LAST_WORD) state_d = IDLE;
                    end
                end
                RUN: begin
                    imem_addr = fpc_q[ADDR_W+1:2];
                    if (halt_req) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else if (bad_addr) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else if (redirect) begin
                        fpc_d   = branch_target;
                        valid_d = 1'b0;
                    end else if (!stall) begin
                        imem_re = 1'b1;
                        fpc_d   = fpc_q + 32'd4;
                        pc_d    = fpc_q;
                        valid_d = 1'b1;
                    end
                end
                default: valid_d = 1'b0;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end
    assign instr_out   = imem_rdata;
    assign instr_valid = valid_q;
    assign pc_out      = pc_q;
    assign ld_count    = cnt_q;
    assign state       = state_q;
    assign fault       = fault_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench; a spec-level model predicts
// writes, reads and delivered instructions, and independent monitors compare them.
module tb_fetch_sequencer;
    localparam int RS = 1, SL = 2, RN = 4, LV = 8, LL = 16, ST = 32, BT = 64, HR = 128;
    logic clk = 0, reset = 1, start_load = 0, run = 0, ld_valid = 0, ld_last = 0;
    logic stall = 0, branch_taken = 0, halt_req = 0;
    logic [31:0] ld_data = 0, branch_target = 0, imem_rdata = 0, imem_wdata, instr_out, pc_out;
    logic ld_ready, imem_we, imem_re, instr_valid, fault;
    logic [5:0] imem_addr;
    logic [6:0] ld_count;
    logic [1:0] state;
    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start_load(start_load), .run(run), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt_req(halt_req),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_re(imem_re),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
        .pc_out(pc_out), .ld_count(ld_count), .state(state), .fault(fault)
    );
    always #5 clk = ~clk;
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        if (imem_re) imem_rdata <= mem[imem_addr];
    end
    typedef struct { int due; logic [31:0] pc; logic [31:0] ins; } fe_t;
    typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
    fe_t fq[$];
    wr_t wq[$];
    fe_t fe;
    wr_t we_e;
    int total = 0, bad = 0, cyc = 0;
    int mstate, mcnt;
    logic [31:0] mfpc, mpc, minstr;
    logic mvalid, mfault, exp_re = 0;
    logic [5:0] exp_ra = 0;
    logic [31:0] exp_mem [64];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask
    // monitors: compare DUT activity against what the model queued
    always @(negedge clk) begin
        if (instr_valid) begin
            if (fq.size() == 0) flag("fetch_unexpected_valid");
            else begin
                fe = fq.pop_front();
                chk("fetch_due", cyc, fe.due);
                chk("fetch_pc", pc_out, fe.pc);
                chk("fetch_instr", instr_out, fe.ins);
            end
        end else if (fq.size() > 0 && fq[0].due <= cyc) begin
            void'(fq.pop_front());
            flag("fetch_missing_valid");
        end
        chk("imem_re", {31'd0, imem_re}, {31'd0, exp_re});
        if (exp_re) chk("imem_raddr", {26'd0, imem_addr}, {26'd0, exp_ra});
        if (imem_we) begin
            if (wq.size() == 0) flag("write_unexpected");
            else begin
                we_e = wq.pop_front();
                chk("write_addr", {26'd0, imem_addr}, {26'd0, we_e.a});
                chk("write_data", imem_wdata, we_e.d);
            end
        end else if (wq.size() > 0) begin
            wq.delete();
            flag("write_missing");
        end
    end
    task automatic model_reset();
        mstate = 0; mcnt = 0; mfpc = 0; mpc = 0; minstr = 0; mvalid = 0; mfault = 0;
    endtask
    task automatic step(input int f, input logic [31:0] d, input logic [31:0] tg);
        logic redir;
        logic [31:0] a;
        @(posedge clk);
        #1;
        chk("state", {30'd0, state}, 32'(mstate));
        chk("ld_count", {25'd0, ld_count}, 32'(mcnt));
        chk("fault", {31'd0, fault}, {31'd0, mfault});
        chk("pc_out", pc_out, mpc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, mvalid});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, mstate == 1});
        reset = (f & RS) != 0; start_load = (f & SL) != 0; run = (f & RN) != 0;
        ld_valid = (f & LV) != 0; ld_last = (f & LL) != 0; stall = (f & ST) != 0;
        branch_taken = (f & BT) != 0; halt_req = (f & HR) != 0;
        ld_data = d; branch_target = tg;
        exp_re = 0;
        if (reset) model_reset();
        else if (mstate == 0) begin
            if (start_load) begin mstate = 1; mcnt = 0; end
            else if (run) mstate = 2;
        end else if (mstate == 1) begin
            if (ld_valid) begin
                wq.push_back('{6'(mcnt), d});
                exp_mem[mcnt] = d;
                mcnt++;
                if (ld_last || mcnt == 64) mstate = 0;
            end
        end else if (mstate == 2) begin
            redir = branch_taken && mvalid;
            a = redir ? tg : mfpc;
            if (halt_req) begin mstate = 3; mvalid = 0; end
            else if (a[1:0] != 0 || a[31:8] != 0) begin mfault = 1; mstate = 3; mvalid = 0; end
            else if (redir) begin mfpc = tg; mvalid = 0; end
            else if (!stall) begin
                exp_re = 1; exp_ra = mfpc[7:2];
                mpc = mfpc; minstr = exp_mem[mfpc[7:2]];
                mfpc += 4; mvalid = 1;
            end
        end
        if (mvalid) fq.push_back('{cyc + 1, mpc, minstr});
    endtask
    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 11) == 0) t = ($urandom_range(0, 1) != 0) ? (t | 32'h2) : (t | 32'h100);
        return t;
    endfunction
    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = 0; exp_mem[i] = 0; end
        model_reset();
        step(RS, 0, 0); step(RS, 0, 0);
        step(SL, 0, 0);
        for (int i = 0; i < 3; i++) step(LV, $urandom, 0);
        step(RS, 0, 0); step(0, 0, 0);
        step(SL, 0, 0);
        step(LV, 32'h11, 0); step(LV, 32'h22, 0); step(LV, 32'h33, 0); step(LV | LL, 32'h44, 0);
        step(0, 0, 0);
        step(SL, 0, 0); step(LV, $urandom, 0); step(0, 0, 0); step(LV | LL, $urandom, 0); step(0, 0, 0);
        step(SL, 0, 0);
        for (int i = 0; i < 67; i++) step(LV, $urandom, 0);
        step(RN | SL, 0, 0);
        step(SL, 0, 0);
        for (int i = 0; i < 64; i++) step(LV | ((i == 63) ? LL : 0), $urandom, 0);
        step(RN, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(ST, 0, 0);
        step(SL, 0, 0); step(0, 0, 0);
        step(ST | BT, 32'h20, 0);
        step(ST | BT, 0, 32'h20);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(BT, 0, 32'h22);
        step(RN, 0, 0); step(0, 0, 0);
        step(RS, 0, 0); step(RN, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(BT, 0, 32'h20);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            step(RS, 0, 0); step(RN, 0, 0);
            for (int i = 0; i < 150 && mstate != 3; i++)
                step((($urandom_range(0, 3) == 0) ? ST : 0) | (($urandom_range(0, 4) == 0) ? BT : 0), 0, rand_target());
            step(0, 0, 0);
        end
        step(RS, 0, 0); step(RN, 0, 0);
        for (int i = 0; i < 80 && mstate != 3; i++) step(0, 0, 0);
        step(0, 0, 0);
        chk("seq_fault_at_0x100", {31'd0, fault}, 32'd1);
        step(RS, 0, 0); step(RN, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(HR | BT, 0, 32'h40);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("halt_no_fault", {30'd0, state, fault}, 32'b110);
        @(negedge clk);
        @(negedge clk);
        chk("fetch_queue_drained", 32'(fq.size()), 0);
        chk("write_queue_drained", 32'(wq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
